// File: rtl/writeback_scoreboard_if.sv
// rtl/writeback_scoreboard_if.sv - expected-entry push stream and regfile write tap
interface writeback_scoreboard_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      exp_valid;
  logic                      exp_ready;
  logic [REG_ADDR_WIDTH-1:0] exp_reg;
  logic [DATA_WIDTH-1:0]     exp_data;
  logic                      exp_last;
  logic                      wb_enable;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0]     wb_data;

  modport master (
    output exp_valid, exp_reg, exp_data, exp_last, wb_enable, wb_reg, wb_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_reg, exp_data, exp_last, wb_enable, wb_reg, wb_data,
    output exp_ready
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// rtl/writeback_scoreboard.sv - in-order checker of regfile writes against a preloaded expected FIFO
module writeback_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int EXP_DEPTH      = 16,
  parameter int CYCLE_LIMIT    = 1000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  writeback_scoreboard_if.slave     bus,
  output logic                      mismatch_pulse,
  output logic [REG_ADDR_WIDTH-1:0] mismatch_reg,
  output logic [DATA_WIDTH-1:0]     mismatch_data,
  output logic [DATA_WIDTH-1:0]     mismatch_expected,
  output logic [CNT_WIDTH-1:0]      error_count,
  output logic [CNT_WIDTH-1:0]      match_count,
  output logic [31:0]               cycle_count,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout
);
  localparam int PTR_W = $clog2(EXP_DEPTH);
  localparam logic [PTR_W:0]     PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W+1)'(EXP_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [31:0]        LIMIT     = 32'(CYCLE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [REG_ADDR_WIDTH-1:0] r_fifo_reg  [EXP_DEPTH];
  logic [DATA_WIDTH-1:0]     r_fifo_data [EXP_DEPTH];
  logic                      r_fifo_last [EXP_DEPTH];
  logic [PTR_W:0]            r_wr_ptr, r_rd_ptr;

  logic                      r_mismatch_pulse;
  logic [REG_ADDR_WIDTH-1:0] r_mismatch_reg;
  logic [DATA_WIDTH-1:0]     r_mismatch_data, r_mismatch_expected;
  logic [CNT_WIDTH-1:0]      r_error_count, r_match_count;
  logic [31:0]               r_cycle_count;
  logic                      r_done, r_timeout;

  logic [PTR_W:0]            w_count;
  logic                      w_full, w_empty, w_in_run, w_push, w_event, w_pop;
  logic                      w_match, w_error, w_last_cmp, w_limit_hit;
  logic [REG_ADDR_WIDTH-1:0] w_head_reg;
  logic [DATA_WIDTH-1:0]     w_head_data;
  logic                      w_head_last;
  logic [31:0]               w_cycle_next;

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_count == DEPTH_CNT);
  assign w_empty     = (w_count == '0);
  assign w_in_run    = (r_state == S_RUN);
  // Fullness is judged before any same-cycle pop, so a pop never makes room for a concurrent push.
  assign w_push      = bus.exp_valid && !w_full && (r_state != S_DONE);
  assign w_event     = w_in_run && bus.wb_enable && (bus.wb_reg != '0);
  assign w_pop       = w_event && !w_empty;
  assign w_head_reg  = r_fifo_reg[r_rd_ptr[PTR_W-1:0]];
  assign w_head_data = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
  assign w_head_last = r_fifo_last[r_rd_ptr[PTR_W-1:0]];
  assign w_match     = w_pop && (w_head_reg == bus.wb_reg) && (w_head_data == bus.wb_data);
  assign w_error     = w_event && !w_match;
  assign w_last_cmp  = w_pop && w_head_last;
  assign w_cycle_next = r_cycle_count + 32'd1;
  assign w_limit_hit = w_in_run && (w_cycle_next == LIMIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last_cmp || w_limit_hit) w_state_next = S_DONE;
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_wr_ptr            <= '0;
      r_rd_ptr            <= '0;
      r_mismatch_pulse    <= 1'b0;
      r_mismatch_reg      <= '0;
      r_mismatch_data     <= '0;
      r_mismatch_expected <= '0;
      r_error_count       <= '0;
      r_match_count       <= '0;
      r_cycle_count       <= '0;
      r_done              <= 1'b0;
      r_timeout           <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_mismatch_pulse <= w_error;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_match && (r_match_count != '1)) r_match_count <= r_match_count + CNT_ONE;
      if (w_error) begin
        if (r_error_count != '1) r_error_count <= r_error_count + CNT_ONE;
        r_mismatch_reg      <= bus.wb_reg;
        r_mismatch_data     <= bus.wb_data;
        r_mismatch_expected <= w_pop ? w_head_data : '0;
      end
      if (w_in_run) r_cycle_count <= w_cycle_next;
      if (w_last_cmp || w_limit_hit) r_done <= 1'b1;
      if (w_limit_hit) r_timeout <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which slots are live.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_reg[r_wr_ptr[PTR_W-1:0]]  <= bus.exp_reg;
      r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= bus.exp_data;
      r_fifo_last[r_wr_ptr[PTR_W-1:0]] <= bus.exp_last;
    end
  end

  assign bus.exp_ready      = !w_full;
  assign mismatch_pulse     = r_mismatch_pulse;
  assign mismatch_reg       = r_mismatch_reg;
  assign mismatch_data      = r_mismatch_data;
  assign mismatch_expected  = r_mismatch_expected;
  assign error_count        = r_error_count;
  assign match_count        = r_match_count;
  assign cycle_count        = r_cycle_count;
  assign done               = r_done;
  assign timeout            = r_timeout;
  assign pass               = r_done && (r_error_count == '0) && !r_timeout;
endmodule

// File: tb/tb_writeback_scoreboard.sv
// tb/tb_writeback_scoreboard.sv - randomized scoreboard bench with a queue-based reference model
module tb_writeback_scoreboard;
  localparam int DW    = 16;
  localparam int RAW   = 4;
  localparam int DEPTH = 4;
  localparam int LIMIT = 40;
  localparam int CNT   = 3;
  localparam int CMAX  = (1 << CNT) - 1;

  logic clock = 1'b0;
  logic reset, start;
  always #5 clock = ~clock;

  writeback_scoreboard_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) bus ();

  logic           mismatch_pulse, done, pass, timeout;
  logic [RAW-1:0] mismatch_reg;
  logic [DW-1:0]  mismatch_data, mismatch_expected;
  logic [CNT-1:0] error_count, match_count;
  logic [31:0]    cycle_count;

  writeback_scoreboard #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .EXP_DEPTH(DEPTH),
    .CYCLE_LIMIT(LIMIT), .CNT_WIDTH(CNT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .mismatch_pulse(mismatch_pulse), .mismatch_reg(mismatch_reg),
    .mismatch_data(mismatch_data), .mismatch_expected(mismatch_expected),
    .error_count(error_count), .match_count(match_count),
    .cycle_count(cycle_count), .done(done), .pass(pass), .timeout(timeout)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Reference model: expected entries as a plain queue, counters as integers.
  typedef struct {
    logic [RAW-1:0] r;
    logic [DW-1:0]  d;
    bit             last;
  } entry_t;

  typedef struct {
    int             match, err, cyc;
    bit             pulse, done, to, pass;
    logic [RAW-1:0] mreg;
    logic [DW-1:0]  mdata, mexp;
  } resp_t;

  entry_t         m_q[$];
  resp_t          sb[$];
  int             m_state;  // 0 idle, 1 run, 2 done
  int             m_match, m_err, m_cyc;
  bit             m_pulse, m_done, m_to;
  logic [RAW-1:0] m_mreg;
  logic [DW-1:0]  m_mdata, m_mexp;

  task automatic model_step();
    bit push_ok, ev, fin, err;
    entry_t h, n;
    if (reset) begin
      m_q.delete();
      m_state = 0; m_match = 0; m_err = 0; m_cyc = 0;
      m_pulse = 0; m_done = 0; m_to = 0;
      m_mreg = '0; m_mdata = '0; m_mexp = '0;
      return;
    end
    push_ok = bus.exp_valid && (m_q.size() < DEPTH) && (m_state != 2);
    ev = (m_state == 1) && bus.wb_enable && (bus.wb_reg != 0);
    fin = 0; err = 0;
    if (ev) begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        if (h.r == bus.wb_reg && h.d == bus.wb_data) begin
          if (m_match < CMAX) m_match++;
        end else begin
          err = 1; m_mexp = h.d;
        end
        if (h.last) fin = 1;
      end else begin
        err = 1; m_mexp = '0;
      end
      if (err) begin
        if (m_err < CMAX) m_err++;
        m_mreg = bus.wb_reg; m_mdata = bus.wb_data;
      end
    end
    m_pulse = err;
    if (push_ok) begin
      n.r = bus.exp_reg; n.d = bus.exp_data; n.last = bus.exp_last;
      m_q.push_back(n);
    end
    if (m_state == 1) begin
      m_cyc++;
      if (m_cyc == LIMIT) begin m_to = 1; fin = 1; end
    end
    if (fin) begin m_done = 1; m_state = 2; end
    else if (m_state == 0 && start) m_state = 1;
  endtask

  function automatic resp_t snapshot();
    resp_t s;
    s.match = m_match; s.err = m_err; s.cyc = m_cyc;
    s.pulse = m_pulse; s.done = m_done; s.to = m_to;
    s.pass = m_done && (m_err == 0) && !m_to;
    s.mreg = m_mreg; s.mdata = m_mdata; s.mexp = m_mexp;
    return s;
  endfunction

  // Inputs are driven at negedge; the model advances with them and the DUT at the next posedge.
  task automatic tick();
    model_step();
    if (bus.wb_enable) sb.push_back(snapshot());
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0;
    bus.exp_valid = 0; bus.exp_reg = '0; bus.exp_data = '0; bus.exp_last = 0;
    bus.wb_enable = 0; bus.wb_reg = '0; bus.wb_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; tick(); reset = 0;
  endtask

  task automatic push(input int r, input int d, input bit last);
    bus.exp_valid = 1; bus.exp_reg = RAW'(r); bus.exp_data = DW'(d); bus.exp_last = last;
    tick();
    bus.exp_valid = 0; bus.exp_last = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wb(input int r, input int d);
    bus.wb_enable = 1; bus.wb_reg = RAW'(r); bus.wb_data = DW'(d);
    tick();
    bus.wb_enable = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_match"},   match_count, m_match);
    chk({tag, "_err"},     error_count, m_err);
    chk({tag, "_cycles"},  cycle_count, m_cyc);
    chk({tag, "_done"},    done, m_done);
    chk({tag, "_timeout"}, timeout, m_to);
    chk({tag, "_pass"},    pass, m_done && (m_err == 0) && !m_to);
    chk({tag, "_ready"},   bus.exp_ready, m_q.size() < DEPTH);
  endtask

  // Monitor: whenever a write is presented, the DUT response one edge later is checked.
  initial begin
    bit ev;
    resp_t e;
    forever begin
      @(posedge clock);
      ev = (bus.wb_enable === 1'b1);
      #1;
      if (ev) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: write seen with no expected response queued");
        end else begin
          e = sb.pop_front();
          chk("mon_match",    match_count, e.match);
          chk("mon_err",      error_count, e.err);
          chk("mon_pulse",    mismatch_pulse, e.pulse);
          chk("mon_mreg",     mismatch_reg, e.mreg);
          chk("mon_mdata",    mismatch_data, e.mdata);
          chk("mon_mexp",     mismatch_expected, e.mexp);
          chk("mon_done",     done, e.done);
          chk("mon_timeout",  timeout, e.to);
          chk("mon_pass",     pass, e.pass);
          chk("mon_cycles",   cycle_count, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, d;
    idle_inputs();
    @(negedge clock);
    do_reset();
    chk("rst_match", match_count, 0);
    chk("rst_err", error_count, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pulse", mismatch_pulse, 0);
    chk("rst_mexp", mismatch_expected, 0);
    chk("rst_ready", bus.exp_ready, 1);

    push(1, 5, 0); push(2, 7, 1); do_start();
    wb(1, 5); wb(2, 7);
    chk("t1_match", match_count, 2);
    chk("t1_err", error_count, 0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);

    do_reset();
    push(3, 'h10, 1); do_start(); wb(3, 'h11);
    chk("t2_pulse", mismatch_pulse, 1);
    chk("t2_mreg", mismatch_reg, 3);
    chk("t2_mdata", mismatch_data, 'h11);
    chk("t2_mexp", mismatch_expected, 'h10);
    chk("t2_err", error_count, 1);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    idle(1);
    chk("t2_pulse_clear", mismatch_pulse, 0);

    do_reset();
    push(5, 1, 0); do_start();
    idle(LIMIT - 1);
    chk("t3_pre_timeout", timeout, 0);
    chk("t3_pre_cycles", cycle_count, LIMIT - 1);
    idle(1);
    chk("t3_cycles", cycle_count, LIMIT);
    chk("t3_timeout", timeout, 1);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_err", error_count, 0);
    idle(3);
    chk("t3_cycles_hold", cycle_count, LIMIT);

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_ready_open", bus.exp_ready, 1);
      push(i + 1, i * 3 + 1, 0);
    end
    chk("t4_ready_full", bus.exp_ready, 0);
    push(9, 99, 1);
    do_start();
    for (int i = 0; i < DEPTH; i++) wb(i + 1, i * 3 + 1);
    chk("t4_match", match_count, DEPTH);
    chk("t4_err", error_count, 0);
    chk("t4_done", done, 0);
    wb(9, 99);
    chk("t4_dropped_err", error_count, 1);
    chk("t4_dropped_mexp", mismatch_expected, 0);
    chk_model("t4");

    do_reset();
    do_start(); wb(4, 9); wb(0, 3);
    chk("t5_err", error_count, 1);
    chk("t5_mreg", mismatch_reg, 4);
    chk("t5_mexp", mismatch_expected, 0);
    do_reset();
    chk("t5_rst_err", error_count, 0);
    chk("t5_rst_cycles", cycle_count, 0);
    chk("t5_rst_ready", bus.exp_ready, 1);
    wb(4, 9);
    chk("t5_idle_ignored", error_count, 0);

    do_reset();
    do_start();
    for (int i = 0; i < CMAX + 2; i++) wb(1, i);
    chk("t6_err_sat", error_count, CMAX);
    chk("t6_match", match_count, 0);

    for (int round = 0; round < 30; round++) begin
      do_reset();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        push($urandom_range(0, 15), $urandom, (i == n - 1) && ($urandom_range(0, 3) != 0));
      do_start();
      for (int c = 0; c < 60 && m_state != 2; c++) begin
        bus.exp_valid = ($urandom_range(0, 4) == 0);
        bus.exp_reg = RAW'($urandom_range(1, 15));
        bus.exp_data = DW'($urandom);
        bus.exp_last = ($urandom_range(0, 3) == 0);
        bus.wb_enable = ($urandom_range(0, 9) < 6);
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          r = m_q[0].r; d = m_q[0].d;
        end else begin
          r = $urandom_range(0, 15); d = $urandom;
        end
        bus.wb_reg = RAW'(r); bus.wb_data = DW'(d);
        tick();
      end
      idle_inputs();
      wb($urandom_range(1, 15), $urandom);
      chk_model("rand");
    end

    idle(2);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
